// File: rtl/motion_monitor.sv
// Pointer-motion monitor: it filters jitter, tracks INIT/IDLE/MOVING activity and
// queues every real motion event in a first-word-fall-through FIFO.
module motion_monitor #(
    parameter int COORD_W      = 11,
    parameter int DEADBAND     = 0,
    parameter int IDLE_SAMPLES = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                           PS2_CLK,
    input  logic                           reset,
    input  logic                           sample_en,
    input  logic [COORD_W-1:0]             x_in,
    input  logic [COORD_W-1:0]             y_in,
    input  logic [2:0]                     btn_in,
    output logic                           moving,
    output logic                           idle,
    output logic [3:0]                     dir,
    output logic signed [COORD_W:0]        dx,
    output logic signed [COORD_W:0]        dy,
    output logic                           evt_valid,
    output logic [3+2*COORD_W-1:0]         evt_data,
    input  logic                           evt_ready,
    output logic [$clog2(FIFO_DEPTH):0]    evt_count,
    output logic                           evt_overflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int DATA_W = 3 + 2 * COORD_W;
    localparam int QW     = $clog2(IDLE_SAMPLES + 1);
    localparam logic [COORD_W:0] DB = DEADBAND[COORD_W:0];

    typedef enum logic [1:0] {INIT, IDLE, MOVING} state_t;

    state_t                    state_q, state_d;
    logic [QW-1:0]             quiet_q, quiet_d;
    logic [COORD_W-1:0]        prev_x_q, prev_x_d, prev_y_q, prev_y_d;
    logic [2:0]                prev_btn_q, prev_btn_d;
    logic signed [COORD_W:0]   dx_q, dx_d, dy_q, dy_d;
    logic [3:0]                dir_q, dir_d;
    logic                      moving_q, moving_d, idle_q, idle_d;
    logic [DATA_W-1:0]         mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]         mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      ovf_q, ovf_d;

    logic signed [COORD_W:0]   diff_x, diff_y;
    logic [COORD_W:0]          abs_x, abs_y;
    logic                      motion, push, pop, full, wr_en;

    // Displacements are taken one bit wider than the coordinates so they never wrap.
    always_comb begin
        diff_x = $signed({1'b0, x_in}) - $signed({1'b0, prev_x_q});
        diff_y = $signed({1'b0, y_in}) - $signed({1'b0, prev_y_q});
        abs_x  = diff_x[COORD_W] ? -diff_x : diff_x;
        abs_y  = diff_y[COORD_W] ? -diff_y : diff_y;
        motion = (abs_x > DB) || (abs_y > DB) || (btn_in != prev_btn_q);
        push   = sample_en && (state_q != INIT) && motion;
    end

    always_comb begin
        state_d = state_q;
        quiet_d = quiet_q;
        if (sample_en) begin
            case (state_q)
                INIT: state_d = IDLE;
                IDLE: begin
                    if (motion) begin
                        state_d = MOVING;
                        quiet_d = '0;
                    end
                end
                MOVING: begin
                    if (motion) begin
                        quiet_d = '0;
                    end else if (quiet_q == QW'(IDLE_SAMPLES - 1)) begin
                        state_d = IDLE;
                        quiet_d = '0;
                    end else begin
                        quiet_d = quiet_q + QW'(1);
                    end
                end
                default: state_d = INIT;
            endcase
        end
    end

    always_comb begin
        moving_d = (state_d == MOVING);
        idle_d   = (state_d == IDLE);
    end

    // prev_* only follow the inputs on real motion, so slow drift still adds up.
    always_comb begin
        prev_x_d   = prev_x_q;
        prev_y_d   = prev_y_q;
        prev_btn_d = prev_btn_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        dir_d      = dir_q;
        if ((sample_en && state_q == INIT) || push) begin
            prev_x_d   = x_in;
            prev_y_d   = y_in;
            prev_btn_d = btn_in;
        end
        if (push) begin
            dx_d  = diff_x;
            dy_d  = diff_y;
            dir_d = {diff_y[COORD_W], !diff_y[COORD_W] && (diff_y != '0),
                     diff_x[COORD_W], !diff_x[COORD_W] && (diff_x != '0)};
        end
    end

    // A full FIFO still accepts a push when a pop frees the head in the same cycle.
    always_comb begin
        full     = (count_q == CNT_W'(FIFO_DEPTH));
        pop      = (count_q != '0) && evt_ready;
        wr_en    = push && (!full || pop);
        ovf_d    = ovf_q || (push && full && !pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = {btn_in, x_in, y_in};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (wr_en && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !wr_en) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge PS2_CLK) begin
        if (reset) begin
            state_q    <= INIT;
            quiet_q    <= '0;
            prev_x_q   <= '0;
            prev_y_q   <= '0;
            prev_btn_q <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            dir_q      <= '0;
            moving_q   <= 1'b0;
            idle_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            quiet_q    <= quiet_d;
            prev_x_q   <= prev_x_d;
            prev_y_q   <= prev_y_d;
            prev_btn_q <= prev_btn_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            dir_q      <= dir_d;
            moving_q   <= moving_d;
            idle_q     <= idle_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge PS2_CLK) begin
        mem_q <= mem_d;
    end

    assign moving       = moving_q;
    assign idle         = idle_q;
    assign dir          = dir_q;
    assign dx           = dx_q;
    assign dy           = dy_q;
    assign evt_valid    = (count_q != '0);
    assign evt_data     = mem_q[rd_ptr_q];
    assign evt_count    = count_q;
    assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_motion_monitor.sv
// Directed bench for motion_monitor with COORD_W=11, DEADBAND=2, IDLE_SAMPLES=4,
// FIFO_DEPTH=4; every expected value below was worked out by hand.
module tb_motion_monitor;

    logic          PS2_CLK = 1'b0;
    logic          reset = 1'b0;
    logic          sample_en = 1'b0;
    logic [10:0]   x_in = '0;
    logic [10:0]   y_in = '0;
    logic [2:0]    btn_in = '0;
    logic          evt_ready = 1'b0;
    logic          moving, idle, evt_valid, evt_overflow;
    logic [3:0]    dir;
    logic signed [11:0] dx, dy;
    logic [24:0]   evt_data;
    logic [2:0]    evt_count;

    int compared = 0;
    int mismatched = 0;

    motion_monitor #(
        .COORD_W(11), .DEADBAND(2), .IDLE_SAMPLES(4), .FIFO_DEPTH(4)
    ) dut (
        .PS2_CLK(PS2_CLK), .reset(reset), .sample_en(sample_en),
        .x_in(x_in), .y_in(y_in), .btn_in(btn_in),
        .moving(moving), .idle(idle), .dir(dir), .dx(dx), .dy(dy),
        .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready),
        .evt_count(evt_count), .evt_overflow(evt_overflow)
    );

    always #5 PS2_CLK = ~PS2_CLK;

    function automatic logic [24:0] mkEvt(input logic [2:0] b, input logic [10:0] x,
                                          input logic [10:0] y);
        return {b, x, y};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, sample 1ns after the rising edge.
    task automatic applyStimulus(input logic rst, input logic sen, input logic [10:0] x,
                                 input logic [10:0] y, input logic [2:0] b, input logic rdy);
        @(negedge PS2_CLK);
        reset = rst; sample_en = sen; x_in = x; y_in = y; btn_in = b; evt_ready = rdy;
        @(posedge PS2_CLK);
        #1;
        reset = 1'b0; sample_en = 1'b0; evt_ready = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_moving"}, {31'b0, moving}, 32'd0);
        checkOutput({tag, "_idle"}, {31'b0, idle}, 32'd0);
        checkOutput({tag, "_dir"}, {28'b0, dir}, 32'd0);
        checkOutput({tag, "_dx"}, {20'b0, dx}, 32'd0);
        checkOutput({tag, "_dy"}, {20'b0, dy}, 32'd0);
        checkOutput({tag, "_valid"}, {31'b0, evt_valid}, 32'd0);
        checkOutput({tag, "_count"}, {29'b0, evt_count}, 32'd0);
        checkOutput({tag, "_ovf"}, {31'b0, evt_overflow}, 32'd0);
    endtask

    initial begin
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkResetState("rst");

        applyStimulus(0, 1, 100, 100, 0, 0);
        checkOutput("init_idle", {31'b0, idle}, 32'd1);
        checkOutput("init_moving", {31'b0, moving}, 32'd0);
        checkOutput("init_valid", {31'b0, evt_valid}, 32'd0);
        checkOutput("init_count", {29'b0, evt_count}, 32'd0);

        applyStimulus(0, 1, 102, 100, 0, 0);
        checkOutput("db_idle", {31'b0, idle}, 32'd1);
        checkOutput("db_count", {29'b0, evt_count}, 32'd0);

        applyStimulus(0, 1, 103, 100, 0, 0);
        checkOutput("mv_moving", {31'b0, moving}, 32'd1);
        checkOutput("mv_idle", {31'b0, idle}, 32'd0);
        checkOutput("mv_dx", {20'b0, dx}, 32'd3);
        checkOutput("mv_dy", {20'b0, dy}, 32'd0);
        checkOutput("mv_dir", {28'b0, dir}, 32'b0001);
        checkOutput("mv_data", {7'b0, evt_data}, {7'b0, mkEvt(0, 103, 100)});
        checkOutput("mv_count", {29'b0, evt_count}, 32'd1);

        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("pop1_count", {29'b0, evt_count}, 32'd0);
        checkOutput("pop1_moving", {31'b0, moving}, 32'd1);

        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 1, 103, 100, 0, 0);
            if (i == 3) checkOutput("quiet3_moving", {31'b0, moving}, 32'd1);
        end
        checkOutput("quiet4_idle", {31'b0, idle}, 32'd1);
        checkOutput("quiet4_moving", {31'b0, moving}, 32'd0);
        checkOutput("quiet4_count", {29'b0, evt_count}, 32'd0);

        applyStimulus(0, 1, 103, 100, 1, 0);
        checkOutput("btn_moving", {31'b0, moving}, 32'd1);
        checkOutput("btn_dx", {20'b0, dx}, 32'd0);
        checkOutput("btn_dir", {28'b0, dir}, 32'd0);
        checkOutput("btn_data", {7'b0, evt_data}, {7'b0, mkEvt(1, 103, 100)});
        checkOutput("btn_count", {29'b0, evt_count}, 32'd1);

        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("pop2_count", {29'b0, evt_count}, 32'd0);

        applyStimulus(0, 1, 110, 100, 1, 0);
        applyStimulus(0, 1, 120, 100, 1, 0);
        applyStimulus(0, 1, 120, 90, 1, 0);
        checkOutput("up_dir", {28'b0, dir}, 32'b1000);
        checkOutput("up_dy", {20'b0, dy}, 32'hFF6);
        applyStimulus(0, 1, 120, 90, 0, 0);
        checkOutput("fill4_count", {29'b0, evt_count}, 32'd4);
        checkOutput("fill4_ovf", {31'b0, evt_overflow}, 32'd0);
        applyStimulus(0, 1, 130, 80, 0, 0);
        checkOutput("ovf_count", {29'b0, evt_count}, 32'd4);
        checkOutput("ovf_flag", {31'b0, evt_overflow}, 32'd1);
        checkOutput("ovf_dir", {28'b0, dir}, 32'b1001);
        checkOutput("ovf_head", {7'b0, evt_data}, {7'b0, mkEvt(1, 110, 100)});

        applyStimulus(0, 1, 140, 80, 0, 1);
        checkOutput("fullpp_count", {29'b0, evt_count}, 32'd4);
        checkOutput("fullpp_ovf", {31'b0, evt_overflow}, 32'd1);
        checkOutput("fullpp_dx", {20'b0, dx}, 32'd10);
        checkOutput("drain0", {7'b0, evt_data}, {7'b0, mkEvt(1, 120, 100)});
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("drain1", {7'b0, evt_data}, {7'b0, mkEvt(1, 120, 90)});
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("drain2", {7'b0, evt_data}, {7'b0, mkEvt(0, 120, 90)});
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("drain3", {7'b0, evt_data}, {7'b0, mkEvt(0, 140, 80)});
        checkOutput("drain3_count", {29'b0, evt_count}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("empty_valid", {31'b0, evt_valid}, 32'd0);
        checkOutput("empty_count", {29'b0, evt_count}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("emptypop_count", {29'b0, evt_count}, 32'd0);
        checkOutput("hold_moving", {31'b0, moving}, 32'd1);
        checkOutput("hold_ovf", {31'b0, evt_overflow}, 32'd1);

        applyStimulus(0, 1, 150, 80, 0, 0);
        applyStimulus(0, 1, 160, 80, 0, 0);
        applyStimulus(0, 1, 170, 80, 0, 0);
        checkOutput("pre_rst_count", {29'b0, evt_count}, 32'd3);
        applyStimulus(1, 1, 180, 80, 0, 1);
        checkResetState("midrst");
        applyStimulus(0, 1, 200, 200, 0, 0);
        checkOutput("post_rst_idle", {31'b0, idle}, 32'd1);
        checkOutput("post_rst_valid", {31'b0, evt_valid}, 32'd0);
        checkOutput("post_rst_count", {29'b0, evt_count}, 32'd0);
        checkOutput("post_rst_dx", {20'b0, dx}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/motion_monitor.md
MOTION_MONITOR -- requirements
Module: motion_monitor

Interface
REQ-001 Parameter COORD_W, default 11, width of each coordinate.
REQ-002 Parameter DEADBAND, default 0, largest per-axis displacement ignored as jitter.
REQ-003 Parameter IDLE_SAMPLES, default 16, consecutive motionless samples before the block reports idle.
REQ-004 Parameter FIFO_DEPTH, default 8, event FIFO depth; power of 2, at least 2.
REQ-005 PS2_CLK  input  1  clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high.
REQ-007 sample_en  input  1  qualifies x_in/y_in/btn_in for one cycle.
REQ-008 x_in, y_in  input  COORD_W each  unsigned cursor position.
REQ-009 btn_in  input  3  {middle,right,left} button levels.
REQ-010 moving  output  1  high in MOVING state.
REQ-011 idle  output  1  high in IDLE state.
REQ-012 dir  output  4  {up,down,left,right} of last detected motion.
REQ-013 dx, dy  output  COORD_W+1 each  signed displacement of last detected motion.
REQ-014 evt_valid  output  1  FIFO non-empty.
REQ-015 evt_data  output  3+2*COORD_W  head entry {btn,x,y}.
REQ-016 evt_ready  input  1  consumer pop; a pop occurs when evt_valid&&evt_ready.
REQ-017 evt_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-018 evt_overflow  output  1  sticky flag; set when an event is dropped.

Function
REQ-019 State machine SHALL have states INIT, IDLE and MOVING; inputs are evaluated only when sample_en=1.
REQ-020 INIT: first sample SHALL load prev_x/prev_y/prev_btn, push no event and go to IDLE.
REQ-021 Motion SHALL be |x_in-prev_x|>DEADBAND or |y_in-prev_y|>DEADBAND or btn_in!=prev_btn, computed at COORD_W+1 signed width.
REQ-022 On motion, prev_* SHALL be loaded with the inputs; without motion, prev_* SHALL hold, so sub-deadband drift accumulates.
REQ-023 On motion, dx=x_in-prev_x and dy=y_in-prev_y SHALL register; right=dx>0, left=dx<0, down=dy>0, up=dy<0; all three outputs hold until the next motion.
REQ-024 IDLE->MOVING on motion; MOVING SHALL clear the quiet counter on every motion and increment it on every motionless sample.
REQ-025 MOVING->IDLE SHALL occur on the edge where the quiet counter reaches IDLE_SAMPLES.
REQ-026 moving and idle SHALL be registered decodes of the state; both are 0 in INIT and they are never both 1.
REQ-027 Each motion SHALL push {btn_in,x_in,y_in} into a first-word-fall-through FIFO; evt_data is valid whenever evt_valid=1.
REQ-028 Push when full without a same-cycle pop: the entry is dropped, FIFO contents are unchanged and evt_overflow=1 until reset.
REQ-029 Push and pop in the same cycle (any occupancy, including full) SHALL both complete; evt_count is unchanged.
REQ-030 Pop when empty SHALL be ignored; pointers wrap modulo FIFO_DEPTH.
REQ-031 sample_en=0 SHALL change only the FIFO (via pops); state, prev_* and the quiet counter hold.

Reset
REQ-032 Reset SHALL force state INIT, moving=0, idle=0, dir=0, dx=0, dy=0, prev_*=0, quiet counter=0, FIFO empty, evt_valid=0, evt_count=0 and evt_overflow=0.
REQ-033 Reset asserted mid-operation SHALL discard all FIFO entries, and reset SHALL take priority over sample_en and evt_ready in the same cycle.

Verification (COORD_W=11, DEADBAND=2, IDLE_SAMPLES=4, FIFO_DEPTH=4)
REQ-034 Reset, then sample (100,100,btn=0) -> idle=1, evt_valid=0, evt_count=0.
REQ-035 Sample (102,100) -> no motion, state IDLE; then (103,100) -> moving=1, dx=+3, dy=0, dir=0001, evt_data={0,103,100}.
REQ-036 From MOVING, 4 samples at (103,100) -> idle=1 after the 4th edge; btn_in 0->1 at the same coordinates -> moving=1, dx=0, event pushed.
REQ-037 5 motions with evt_ready=0 -> evt_count=4, evt_overflow=1, and the 5th entry is absent; 4 pops return entries in push order, then evt_valid=0.
REQ-038 FIFO full, simultaneous motion and pop -> evt_count stays 4, evt_overflow unchanged, new entry at the tail.
REQ-039 Reset pulsed while MOVING with 3 entries queued -> next edge shows all REQ-032 values; the first sample after reset pushes no event.
